// File: rtl/bus_timer_pkg.sv
// Shared definitions for the bridge-bus countdown timer.
// Register map, CTRL fields, reload modes and FSM encodings.
package bus_timer_pkg;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_PRESET = 2'd1;
  localparam logic [1:0] REG_COUNT  = 2'd2;

  localparam int CTRL_EN   = 0;
  localparam int CTRL_MODE = 1;
  localparam int CTRL_IM   = 3;
  localparam int CTRL_BITS = 4;

  localparam logic [1:0] MODE_ONESHOT = 2'b00;
  localparam logic [1:0] MODE_RELOAD  = 2'b01;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CNT  = 2'd2,
    INT  = 2'd3
  } timerState_t;

  // Codes 1x fall back to one-shot behaviour.
  function automatic logic isReload(input logic [1:0] mode);
    return mode == MODE_RELOAD;
  endfunction

endpackage

// File: rtl/timer_prescaler.sv
// Count-rate divider for bus_timer, built only with TIMER_PRESCALE_EN.
// Emits a one-cycle tick every PRESCALE_DIV cycles while clr is low.
`ifdef TIMER_PRESCALE_EN
module timer_prescaler #(
  parameter int PRESCALE_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic tick
);

  localparam int W = $clog2(PRESCALE_DIV);
  localparam logic [W-1:0] LAST = W'(PRESCALE_DIV - 1);

  logic [W-1:0] cnt;

  assign tick = ~clr & (cnt == LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clr || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule
`endif

// File: rtl/bus_timer.sv
// Memory-mapped 32-bit countdown timer: CTRL/PRESET/COUNT, FSM, read mux.
// Define TIMER_PRESCALE_EN to slow the count by PRESCALE_DIV.
module bus_timer
  import bus_timer_pkg::*;
#(
  parameter int PRESCALE_DIV = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  addr,
  input  logic        we,
  input  logic [31:0] wd,
  output logic [31:0] rd,
  output logic        irq
);

  if (PRESCALE_DIV < 2) begin : gDivCheck
    $error("bus_timer: PRESCALE_DIV must be at least 2");
  end

  timerState_t state;
  timerState_t stateNext;

  logic        ctrlEn;
  logic        ctrlIm;
  logic [1:0]  ctrlMode;
  logic [31:0] presetReg;
  logic [31:0] countReg;
  logic [31:0] countNext;
  logic        pending;

  logic ctrlWr;
  logic presetWr;
  logic killEn;
  logic setPending;
  logic clrPending;
  logic fsmClrEn;
  logic tick;

  assign ctrlWr   = we & (addr == REG_CTRL);
  assign presetWr = we & (addr == REG_PRESET);
  assign killEn   = ctrlWr & ~wd[CTRL_EN];

`ifdef TIMER_PRESCALE_EN
  logic prescClr;

  assign prescClr = (state == LOAD) | ~ctrlEn;

  timer_prescaler #(
    .PRESCALE_DIV(PRESCALE_DIV)
  ) uPrescaler (
    .clk  (clk),
    .reset(reset),
    .clr  (prescClr),
    .tick (tick)
  );
`else
  assign tick = 1'b1;
`endif

  always_comb begin
    stateNext  = state;
    countNext  = countReg;
    setPending = 1'b0;
    clrPending = 1'b0;
    fsmClrEn   = 1'b0;
    unique case (state)
      IDLE: begin
        if (ctrlEn) begin
          stateNext = LOAD;
        end
      end
      LOAD: begin
        countNext = presetReg;
        stateNext = CNT;
      end
      CNT: begin
        if (!ctrlEn) begin
          stateNext = IDLE;
        end else if (tick) begin
          if (countReg > 32'd1) begin
            countNext = countReg - 32'd1;
          end else begin
            countNext  = '0;
            setPending = 1'b1;
            stateNext  = INT;
          end
        end
      end
      INT: begin
        if (isReload(ctrlMode)) begin
          clrPending = 1'b1;
          stateNext  = LOAD;
        end else begin
          fsmClrEn  = 1'b1;
          stateNext = IDLE;
        end
      end
    endcase
    // A CPU write of EN=0 aborts whatever the FSM was about to do.
    if (killEn) begin
      stateNext  = IDLE;
      countNext  = countReg;
      setPending = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      ctrlEn    <= 1'b0;
      ctrlIm    <= 1'b0;
      ctrlMode  <= MODE_ONESHOT;
      presetReg <= '0;
      countReg  <= '0;
      pending   <= 1'b0;
    end else begin
      state    <= stateNext;
      countReg <= countNext;
      if (ctrlWr) begin
        ctrlEn   <= wd[CTRL_EN];
        ctrlMode <= wd[CTRL_MODE +: 2];
        ctrlIm   <= wd[CTRL_IM];
      end else if (fsmClrEn) begin
        ctrlEn <= 1'b0;
      end
      if (presetWr) begin
        presetReg <= wd;
      end
      if (setPending) begin
        pending <= 1'b1;
      end else if (ctrlWr || presetWr || clrPending) begin
        pending <= 1'b0;
      end
    end
  end

  always_comb begin
    rd = '0;
    case (addr)
      REG_CTRL:   rd = {{(32-CTRL_BITS){1'b0}}, ctrlIm, ctrlMode, ctrlEn};
      REG_PRESET: rd = presetReg;
      REG_COUNT:  rd = countReg;
      default:    rd = '0;
    endcase
  end

  assign irq = ctrlIm & pending;

endmodule
